reg_bank_arbiter: RTL and testbench

Shares one bank of `register` instances between several write requesters and sequences bulk clears of that bank. Each cycle it round-robin arbitrates valid/ready write requests and drives a registered per-register `clk_en` strobe plus a shared write-data bus into the bank. On command it takes exclusive control and writes `RESET_VALUE` into every register, one per cycle. It sits between the GEMM control/streaming engines and the shared configuration/accumulator register bank.

---
 rtl/reg_bank_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/reg_bank_arbiter.sv | 109 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types for the register-bank write arbiter.
package reg_bank_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } reg_bank_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant with a registered priority pointer.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  valid,
    input  logic                update,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any
);

    logic [ID_WIDTH-1:0] ptr;
    int                  idx;

    // Search upward from ptr, wrapping; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter for a shared register bank, with a sequenced
// bulk clear that takes exclusive control of the bank.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]   i_req_data,
    input  logic                                 i_clear,
    output logic [NUM_REGS-1:0]                  o_wr_en,
    output logic [WORD_WIDTH-1:0]                o_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]           o_wr_id,
    output logic                                 o_clear_done,
    output logic                                 o_busy
);

    localparam int ID_WIDTH = $clog2(NUM_REQ);

    reg_bank_state_t       state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  any_grant;
    logic                  arb_en;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   wr_dec;
    logic [NUM_REGS-1:0]   clr_dec;

    // A pending clear wins over any request in the same cycle.
    assign arb_en      = (state == ST_ARB) && !i_clear;
    assign o_req_ready = arb_en ? grant : '0;
    assign xfer        = arb_en && any_grant;
    assign sel_addr    = i_req_addr[grant_idx];
    assign sel_data    = i_req_data[grant_idx];
    assign o_busy      = (state == ST_CLEAR);

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .valid     (i_req_valid),
        .update    (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_grant)
    );

    // Out-of-range addresses decode to no strobe at all.
    always_comb begin
        wr_dec  = '0;
        clr_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_dec[r]  = (int'(sel_addr) == r);
            clr_dec[r] = (int'(clr_cnt) == r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ARB;
            clr_cnt      <= '0;
            o_wr_en      <= '0;
            o_wr_data    <= '0;
            o_wr_id      <= '0;
            o_clear_done <= 1'b0;
        end else begin
            o_wr_en      <= '0;
            o_clear_done <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (i_clear) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end else if (xfer) begin
                        o_wr_en   <= wr_dec;
                        o_wr_data <= sel_data;
                        o_wr_id   <= grant_idx;
                    end
                end
                ST_CLEAR: begin
                    o_wr_en   <= clr_dec;
                    o_wr_data <= RESET_VALUE;
                    o_wr_id   <= '0;
                    clr_cnt   <= clr_cnt + 1'b1;
                    // Done pulse lands with the final clear strobe.
                    if (int'(clr_cnt) == NUM_REGS - 1) begin
                        state        <= ST_ARB;
                        o_clear_done <= 1'b1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized checks of reg_bank_arbiter against a behavioural model.
module tb_reg_bank_arbiter;

    logic             clk;
    logic             reset;
    logic [3:0]       valid;
    logic [3:0]       ready;
    logic [3:0][2:0]  addr;
    logic [3:0][31:0] data;
    logic             clr;
    logic [7:0]       wr_en;
    logic [31:0]      wr_data;
    logic [1:0]       wr_id;
    logic             done;
    logic             busy;

    // Second instance with a non-power-of-two bank for out-of-range addresses.
    logic [3:0]       v2;
    logic [3:0]       r2;
    logic [3:0][2:0]  a2;
    logic [3:0][31:0] d2;
    logic             clr2;
    logic [5:0]       w2en;
    logic [31:0]      w2data;
    logic [1:0]       w2id;
    logic             w2done;
    logic             w2busy;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int          m_ptr = 0;
    int          m_clr = 0;
    logic [3:0]  exp_ready, act_ready, act_ready2;
    logic [7:0]  exp_en;
    logic [31:0] exp_data;
    logic [1:0]  exp_id;
    logic        exp_done, exp_busy;

    reg_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .WORD_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .i_req_valid(valid), .o_req_ready(ready),
        .i_req_addr(addr), .i_req_data(data), .i_clear(clr), .o_wr_en(wr_en),
        .o_wr_data(wr_data), .o_wr_id(wr_id), .o_clear_done(done), .o_busy(busy)
    );

    reg_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .WORD_WIDTH(32)) dut6 (
        .clk(clk), .reset(reset), .i_req_valid(v2), .o_req_ready(r2),
        .i_req_addr(a2), .i_req_data(d2), .i_clear(clr2), .o_wr_en(w2en),
        .o_wr_data(w2data), .o_wr_id(w2id), .o_clear_done(w2done), .o_busy(w2busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumes one clock cycle: sample ready, advance the model, land on the next negedge.
    task automatic step();
        int g;
        int j;
        #1;
        g = -1;
        if (m_clr == 0 && !clr)
            for (int i = 0; i < 4; i++) begin
                j = (m_ptr + i) % 4;
                if (g < 0 && valid[j]) g = j;
            end
        exp_ready  = (g >= 0) ? 4'(1 << g) : 4'h0;
        act_ready  = ready;
        act_ready2 = r2;
        exp_en     = 8'h00;
        exp_done   = 1'b0;
        if (reset) begin
            m_ptr = 0; m_clr = 0; exp_data = 32'h0; exp_id = 2'd0;
        end else if (m_clr > 0) begin
            exp_en = 8'(1 << (8 - m_clr)); exp_data = 32'h0; exp_id = 2'd0;
            m_clr--;
            exp_done = (m_clr == 0);
        end else if (clr) begin
            m_clr = 8;
        end else if (g >= 0) begin
            exp_en = 8'(1 << addr[g]); exp_data = data[g]; exp_id = 2'(g);
            m_ptr = (g + 1) % 4;
        end
        exp_busy = (m_clr > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (wr_en !== 8'h00) begin fails++; $display("FAIL reset_wr_en: got %h want 00", wr_en); end
        checks++; if (wr_data !== 32'h0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        checks++; if (wr_id !== 2'd0) begin fails++; $display("FAIL reset_wr_id: got %0d want 0", wr_id); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_fairness();
        reset = 1'b1; step(); reset = 1'b0;
        valid = 4'hf;
        for (int j = 0; j < 4; j++) begin addr[j] = 3'(j); data[j] = 32'h100 + j; end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (act_ready !== 4'(1 << (i % 4))) begin fails++; $display("FAIL fair_ready[%0d]: got %b want %b", i, act_ready, 4'(1 << (i % 4))); end
            checks++; if (wr_en !== 8'(1 << (i % 4))) begin fails++; $display("FAIL fair_wr_en[%0d]: got %h want %h", i, wr_en, 8'(1 << (i % 4))); end
            checks++; if (wr_id !== 2'(i % 4)) begin fails++; $display("FAIL fair_wr_id[%0d]: got %0d want %0d", i, wr_id, i % 4); end
        end
        valid = 4'h0; step();
    endtask

    task automatic test_skip_idle();
        int seq [3] = '{3, 0, 3};
        valid = 4'b0001; step();  // pointer moves to 1
        valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (act_ready !== 4'(1 << seq[i])) begin fails++; $display("FAIL skip_ready[%0d]: got %b want %b", i, act_ready, 4'(1 << seq[i])); end
        end
        valid = 4'h0; step();
    endtask

    task automatic test_single_write();
        addr[2] = 3'd5; data[2] = 32'hDEADBEEF; valid = 4'b0100;
        step();
        valid = 4'h0;
        checks++; if (act_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", act_ready); end
        checks++; if (wr_en !== 8'h20) begin fails++; $display("FAIL single_wr_en: got %h want 20", wr_en); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
        checks++; if (wr_id !== 2'd2) begin fails++; $display("FAIL single_wr_id: got %0d want 2", wr_id); end
        checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL single_flags: got %b want 00", {done, busy}); end
        step();
        checks++; if (wr_en !== 8'h00) begin fails++; $display("FAIL single_idle: got %h want 00", wr_en); end
    endtask

    task automatic test_clear_vs_request();
        addr[1] = 3'd1; data[1] = 32'h1234_5678; valid = 4'b0010; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (act_ready !== 4'b0000) begin fails++; $display("FAIL clr_ready_t: got %b want 0000", act_ready); end
        checks++; if ({busy, wr_en} !== 9'h100) begin fails++; $display("FAIL clr_enter: got %h want 100", {busy, wr_en}); end
        for (int j = 1; j <= 8; j++) begin
            step();
            checks++; if (act_ready !== 4'b0000) begin fails++; $display("FAIL clr_ready[%0d]: got %b want 0000", j, act_ready); end
            checks++; if (wr_en !== 8'(1 << (j - 1)) || wr_data !== 32'h0) begin fails++; $display("FAIL clr_strobe[%0d]: got %h/%h want %h/0", j, wr_en, wr_data, 8'(1 << (j - 1))); end
            checks++; if (done !== (j == 8) || busy !== (j < 8)) begin fails++; $display("FAIL clr_flags[%0d]: got done %b busy %b", j, done, busy); end
        end
        step();
        valid = 4'h0;
        checks++; if (act_ready !== 4'b0010) begin fails++; $display("FAIL clr_after_ready: got %b want 0010", act_ready); end
        checks++; if (wr_en !== 8'h02 || wr_id !== 2'd1) begin fails++; $display("FAIL clr_after_write: got %h id %0d want 02 id 1", wr_en, wr_id); end
    endtask

    task automatic test_reset_mid_clear();
        clr = 1'b1; step(); clr = 1'b0;
        step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if ({wr_en, busy, done} !== 10'h0) begin fails++; $display("FAIL rstclr_out: got %h want 0", {wr_en, busy, done}); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({wr_en, busy, done} !== 10'h0) begin fails++; $display("FAIL rstclr_quiet[%0d]: got %h want 0", i, {wr_en, busy, done}); end
        end
        valid = 4'hf;
        for (int j = 0; j < 4; j++) addr[j] = 3'(j);
        step();
        valid = 4'h0;
        checks++; if (act_ready !== 4'b0001) begin fails++; $display("FAIL rstclr_first_grant: got %b want 0001", act_ready); end
        step();
    endtask

    task automatic test_out_of_range();
        a2[0] = 3'd7; d2[0] = $urandom; v2 = 4'b0001;
        step();
        v2 = 4'h0;
        checks++; if (act_ready2 !== 4'b0001) begin fails++; $display("FAIL oor_ready: got %b want 0001", act_ready2); end
        checks++; if (w2en !== 6'h00) begin fails++; $display("FAIL oor_wr_en: got %h want 00", w2en); end
        a2[0] = 3'd3; v2 = 4'b0001;
        step();
        v2 = 4'h0;
        checks++; if (w2en !== 6'h08) begin fails++; $display("FAIL oor_inrange: got %h want 08", w2en); end
        step();
    endtask

    task automatic test_random();
        logic was_reset;
        for (int c = 0; c < 500; c++) begin
            was_reset = reset;
            step();
            if (!was_reset) begin
                checks++; if (act_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, act_ready, exp_ready); end
            end
            checks++; if (wr_en !== exp_en || done !== exp_done || busy !== exp_busy) begin
                fails++; $display("FAIL rnd_out[%0d]: got en %h done %b busy %b want en %h done %b busy %b", c, wr_en, done, busy, exp_en, exp_done, exp_busy);
            end
            if (exp_en != 8'h00) begin
                checks++; if (wr_data !== exp_data || wr_id !== exp_id) begin fails++; $display("FAIL rnd_data[%0d]: got %h id %0d want %h id %0d", c, wr_data, wr_id, exp_data, exp_id); end
            end
            for (int j = 0; j < 4; j++)
                if (!valid[j] || (exp_ready[j] && !was_reset)) begin
                    valid[j] = ($urandom_range(0, 2) != 0);
                    addr[j]  = 3'($urandom_range(0, 7));
                    data[j]  = $urandom;
                end
            clr   = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0; clr = 1'b0; valid = 4'h0;
        for (int i = 0; i < 10; i++) step();
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; valid = '0; addr = '0; data = '0;
        v2 = '0; a2 = '0; d2 = '0; clr2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_fairness();
        test_skip_idle();
        test_single_write();
        test_clear_vs_request();
        test_reset_mid_clear();
        test_out_of_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
